i2s_tx_stream: RTL and testbench

Parametrised I2S/left-justified stereo transmitter with a sample FIFO and a ready/valid input, running on one system clock and generating SCLK internally. It replaces the fixed 16-bit, SCLK-clocked transmitter in the audio path. The game sound mixer pushes {left,right} frames; the block serialises them to the codec DAC, pads wide slots, and flags FIFO underruns instead of replaying stale data.

---
 rtl/i2s_tx_stream.sv | 164 ++++++++++++++++
 tb/tb_i2s_tx_stream.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stream.sv
// Stereo I2S / left-justified transmitter with a frame FIFO and an internal SCLK divider.
// Frames are {left, right}; wide slots are zero-padded below the sample.
module i2s_tx_stream #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SLOT_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_on_off,
  input  logic                               i_mode,
  input  logic [2*WIDTH-1:0]                 i_tx,
  input  logic                               i_tx_valid,
  output logic                               o_ready,
  output logic                               o_lrclk,
  output logic                               o_sclk,
  output logic                               o_sd,
  output logic                               o_underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level
);

  localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] SlotBits = BitW'(SLOT_WIDTH);
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               r_state, r_state_d;
  logic [2*WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]      r_level;
  logic [FrameBits-1:0] r_shift, r_shift_d;
  logic [BitW-1:0]      r_bit_cnt, r_bit_cnt_d;
  logic [DivW-1:0]      r_div_cnt, r_div_cnt_d;
  logic                 r_sclk, r_sclk_d;
  logic                 r_lrclk, r_lrclk_d;
  logic                 r_sd, r_sd_d;
  logic                 r_underrun, r_underrun_d;
  logic                 r_dly, r_dly_d;
  logic                 r_mode, r_mode_d;

  logic                 w_push, w_pop, w_empty, w_div_tc, w_fall, w_end, w_frame_start;
  logic [2*WIDTH-1:0]   w_head;
  logic [FrameBits-1:0] w_load;

  assign w_empty       = (r_level == '0);
  assign w_push        = i_tx_valid && (r_level != LvlFull);
  assign w_div_tc      = (r_div_cnt == DivLast);
  assign w_fall        = (r_state == StRun) && w_div_tc && r_sclk;
  assign w_end         = w_fall && (r_bit_cnt == LastBit);
  assign w_frame_start = i_on_off && ((r_state == StIdle) || w_end);
  // Pop decision uses the pre-update level, so a same-cycle push into an empty FIFO waits.
  assign w_pop         = w_frame_start && !w_empty;
  assign w_head        = r_mem[r_rd_ptr];

  always_comb begin
    w_load = '0;
    if (!w_empty) begin
      w_load[FrameBits-1 -: WIDTH]  = w_head[2*WIDTH-1:WIDTH];
      w_load[SLOT_WIDTH-1 -: WIDTH] = w_head[WIDTH-1:0];
    end
  end

  always_comb begin
    r_state_d    = r_state;
    r_shift_d    = r_shift;
    r_bit_cnt_d  = r_bit_cnt;
    r_div_cnt_d  = r_div_cnt;
    r_sclk_d     = r_sclk;
    r_dly_d      = r_dly;
    r_mode_d     = r_mode;
    r_underrun_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_on_off) r_state_d = StRun;
      end
      StRun: begin
        r_div_cnt_d = w_div_tc ? '0 : r_div_cnt + 1'b1;
        if (w_div_tc) r_sclk_d = ~r_sclk;
        if (w_fall) begin
          r_bit_cnt_d = r_bit_cnt + 1'b1;
          r_shift_d   = {r_shift[FrameBits-2:0], 1'b0};
          r_dly_d     = r_shift[FrameBits-1];
        end
        if (w_end && !i_on_off) begin
          r_state_d   = StIdle;
          r_bit_cnt_d = '0;
          r_div_cnt_d = '0;
          r_sclk_d    = 1'b0;
          r_dly_d     = 1'b0;
        end
      end
      default: r_state_d = StIdle;
    endcase
    if (w_frame_start) begin
      r_shift_d    = w_load;
      r_bit_cnt_d  = '0;
      r_div_cnt_d  = '0;
      r_sclk_d     = 1'b0;
      r_mode_d     = i_mode;
      r_underrun_d = w_empty;
    end
    r_sd_d    = (r_state_d == StRun) ? (r_mode_d ? r_shift_d[FrameBits-1] : r_dly_d) : 1'b0;
    r_lrclk_d = (r_state_d == StRun) && (r_bit_cnt_d >= SlotBits);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_sclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
      r_dly      <= 1'b0;
      r_mode     <= 1'b0;
    end else begin
      r_state    <= r_state_d;
      r_shift    <= r_shift_d;
      r_bit_cnt  <= r_bit_cnt_d;
      r_div_cnt  <= r_div_cnt_d;
      r_sclk     <= r_sclk_d;
      r_lrclk    <= r_lrclk_d;
      r_sd       <= r_sd_d;
      r_underrun <= r_underrun_d;
      r_dly      <= r_dly_d;
      r_mode     <= r_mode_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tx;
  end

  assign o_ready    = (r_level != LvlFull);
  assign o_level    = r_level;
  assign o_sclk     = r_sclk;
  assign o_lrclk    = r_lrclk;
  assign o_sd       = r_sd;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Self-checking bench for i2s_tx_stream: vector table, directed frames, and random traffic
// checked cycle by cycle against a frame-timeline reference model.
module tb_i2s_tx_stream;

  localparam int S = 16;
  localparam int D = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 4 * S * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, on_off, mode, tx_valid;
  logic [31:0] tx;
  logic ready, lrclk, sclk, sd, underrun;
  logic [2:0] level;

  logic rst24_n, on24, mode24, val24;
  logic [31:0] tx24;
  logic ready24, lr24, sclk24, sd24, und24;
  logic [2:0] lvl24;

  i2s_tx_stream #(.WIDTH(16), .SLOT_WIDTH(16), .CLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_on_off(on_off), .i_mode(mode), .i_tx(tx),
    .i_tx_valid(tx_valid), .o_ready(ready), .o_lrclk(lrclk), .o_sclk(sclk), .o_sd(sd),
    .o_underrun(underrun), .o_level(level)
  );

  i2s_tx_stream #(.WIDTH(16), .SLOT_WIDTH(24), .CLK_DIV(2), .FIFO_DEPTH(4)) dut24 (
    .i_clk(clk), .i_rst_n(rst24_n), .i_on_off(on24), .i_mode(mode24), .i_tx(tx24),
    .i_tx_valid(val24), .o_ready(ready24), .o_lrclk(lr24), .o_sclk(sclk24), .o_sd(sd24),
    .o_underrun(und24), .o_level(lvl24)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame position as a cycle offset into the frame.
  bit [31:0] mq[$];
  bit        m_run, m_mode, m_prev, m_und;
  int        m_j;
  bit [31:0] m_load;

  function automatic void model_edge();
    int sz;
    bit push, fs;
    if (!rst_n) begin
      mq.delete();
      m_run = 0; m_j = 0; m_prev = 0; m_und = 0; m_load = '0; m_mode = 0;
      return;
    end
    sz = mq.size();
    push = tx_valid && (sz < DEPTH);
    fs = 0;
    if (!m_run) fs = on_off;
    else begin
      m_j++;
      if (m_j == FRAME) begin
        if (on_off) fs = 1;
        else m_run = 0;
      end
    end
    if (fs) begin
      m_prev = m_run ? m_load[0] : 1'b0;
      m_run = 1; m_j = 0; m_mode = mode;
      if (sz > 0) begin m_load = mq.pop_front(); m_und = 0; end
      else begin m_load = '0; m_und = 1; end
    end
    if (push) mq.push_back(tx);
  endfunction

  task automatic model_check();
    int b;
    logic e_sclk, e_lr, e_sd, e_und;
    e_sclk = 0; e_lr = 0; e_sd = 0; e_und = 0;
    if (m_run) begin
      b = m_j / (2 * D);
      e_sclk = ((m_j / D) % 2) == 1;
      e_lr = b >= S;
      e_sd = m_mode ? m_load[2*S-1-b] : ((b == 0) ? m_prev : m_load[2*S-b]);
      e_und = (m_j == 0) && m_und;
    end
    check("sclk", sclk, e_sclk);
    check("lrclk", lrclk, e_lr);
    check("sd", sd, e_sd);
    check("underrun", underrun, e_und);
    check("level", level, mq.size());
    check("ready", ready, mq.size() != DEPTH);
  endtask

  logic [63:0] cap, cap24;
  int cap_n, cap24_n, und_cnt;
  logic prev_sclk = 0, prev_sclk24 = 0;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
    if (sclk && !prev_sclk) begin cap = {cap[62:0], sd}; cap_n++; end
    if (sclk24 && !prev_sclk24) begin cap24 = {cap24[62:0], sd24}; cap24_n++; end
    prev_sclk = sclk;
    prev_sclk24 = sclk24;
    if (underrun) und_cnt++;
  endtask

  typedef struct {
    bit        rst_n;
    bit        valid;
    bit [31:0] data;
    bit        exp_ready;
    bit [2:0]  exp_level;
  } vec_t;

  vec_t vecs[10];
  bit [31:0] f1, f2;
  logic [63:0] exp_cap;
  bit hi_seen;

  initial begin
    vecs[0] = '{0, 1, 32'h1111_1111, 1, 0};
    vecs[1] = '{0, 1, 32'h2222_2222, 1, 0};
    vecs[2] = '{0, 1, 32'h3333_3333, 1, 0};
    vecs[3] = '{1, 0, 32'h0,         1, 0};
    vecs[4] = '{1, 1, 32'hDEAD_0001, 1, 1};
    vecs[5] = '{1, 1, 32'h8001_7FFE, 1, 2};
    vecs[6] = '{1, 1, 32'h0F0F_F0F0, 1, 3};
    vecs[7] = '{1, 1, 32'hC3A5_5A3C, 0, 4};
    vecs[8] = '{1, 1, 32'h5555_5555, 0, 4};
    vecs[9] = '{1, 0, 32'h0,         0, 4};

    rst_n = 0; on_off = 0; mode = 0; tx = '0; tx_valid = 1;
    rst24_n = 0; on24 = 0; mode24 = 0; tx24 = '0; val24 = 0;
    cap = '0; cap24 = '0; cap_n = 0; cap24_n = 0; und_cnt = 0;

    // Reset with TxValid held, then fill past full while stopped.
    for (int i = 0; i < 10; i++) begin
      rst_n = vecs[i].rst_n; tx_valid = vecs[i].valid; tx = vecs[i].data;
      step();
      check($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
    end

    // Drain the four buffered frames left-justified, in order.
    tx_valid = 0; mode = 1; on_off = 1;
    step();
    for (int f = 0; f < 4; f++) begin
      repeat (127) step();
      if (f == 3) on_off = 0;
      step();
      check($sformatf("full_frame%0d", f), cap[31:0], vecs[4+f].data);
    end

    // Single left-justified frame: 128 clocks, no underrun.
    tx = 32'hA5A5_0F0F; tx_valid = 1; step(); tx_valid = 0;
    mode = 1; on_off = 1; und_cnt = 0; cap_n = 0;
    step();
    on_off = 0;
    repeat (126) step();
    check("lj_sclk_last_bit_high", sclk, 1'b1);
    step();
    check("lj_bits", cap[31:0], 32'hA5A5_0F0F);
    check("lj_bit_count", cap_n, 32);
    check("lj_no_underrun", und_cnt, 0);

    // I2S back to back: one-bit delay, second frame bit 0 is the previous LSB.
    f1 = 32'hFFFF_0001; f2 = 32'h8000_0000;
    tx = f1; tx_valid = 1; step(); tx = f2; step(); tx_valid = 0;
    mode = 0; on_off = 1; cap_n = 0;
    step();
    repeat (128) step();
    on_off = 0;
    repeat (128) step();
    exp_cap = {1'b0, f1[31:1], f1[0], f2[31:1]};
    check("i2s_bits", cap, exp_cap);
    check("i2s_bit_count", cap_n, 64);

    // Underrun frame, then a mid-frame push goes out in the following frame.
    mode = 1; on_off = 1; und_cnt = 0;
    step();
    repeat (40) step();
    tx = 32'h1234_5678; tx_valid = 1; step(); tx_valid = 0;
    repeat (87) step();
    on_off = 0;
    repeat (128) step();
    check("und_count", und_cnt, 1);
    check("und_bits", cap, {32'h0, 32'h1234_5678});

    // Random traffic, modes, start/stop and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 1999) != 0);
      tx_valid = ($urandom_range(0, 99) < 2);
      tx = $urandom;
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 299) == 0) on_off = ~on_off;
      else if (c < 20) on_off = 1;
      step();
    end
    rst_n = 1; on_off = 0; tx_valid = 0;
    repeat (FRAME + 4) step();

    // 24-bit slots: padding, stop requested mid-frame, then a mid-frame reset.
    rst24_n = 1; step();
    tx24 = 32'hFFFF_FFFF; val24 = 1; step(); val24 = 0;
    mode24 = 1; on24 = 1; cap24 = '0; cap24_n = 0;
    step();
    repeat (41) step();
    on24 = 0;
    repeat (151) step();
    check("pad_bits", cap24[47:0], 48'hFFFF00_FFFF00);
    check("pad_bit_count", cap24_n, 48);
    hi_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sclk24 || lr24 || sd24) hi_seen = 1;
    end
    check("pad_idle_quiet", hi_seen, 1'b0);

    val24 = 1; step(); step(); val24 = 0;
    on24 = 1;
    step();
    repeat (21) step();
    check("pad_pre_rst_sd", sd24, 1'b1);
    check("pad_pre_rst_level", lvl24, 3'd1);
    rst24_n = 0;
    step();
    check("rst_sclk", sclk24, 1'b0);
    check("rst_lrclk", lr24, 1'b0);
    check("rst_sd", sd24, 1'b0);
    check("rst_underrun", und24, 1'b0);
    check("rst_level", lvl24, 3'd0);
    check("rst_ready", ready24, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
